// File: rtl/alu_rr_arbiter_pkg.sv
// Shared constants for the round-robin ALU arbiter: data width, ALU opcodes, FSM states,
// and the requester-index width helper.
package alu_arb_pkg;

  localparam int DW = 32;

  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_NEG  = 4'd3;
  localparam logic [3:0] ALU_NOT  = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_SLL  = 4'd10;
  localparam logic [3:0] ALU_ROR  = 4'd11;
  localparam logic [3:0] ALU_PASS = 4'd12;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_e;

  // Requester index width; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Request/response bundle between requesters (master) and the ALU arbiter (slave).
// REQ_LOCK exists only when ALU_ARB_LOCK_EN is defined.
interface alu_rr_arbiter_if
  import alu_arb_pkg::*;
#(
    parameter int NREQ = 2
);
    localparam int IW = idx_w(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [4*NREQ-1:0]  req_op;
    logic [DW*NREQ-1:0] req_a;
    logic [DW*NREQ-1:0] req_b;
`ifdef ALU_ARB_LOCK_EN
    logic [NREQ-1:0]    req_lock;
`endif
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IW-1:0]      rsp_id;
    logic [DW-1:0]      rsp_data;

`ifdef ALU_ARB_LOCK_EN
    modport master (output req_valid, req_op, req_a, req_b, req_lock, rsp_ready,
                    input  req_ready, rsp_valid, rsp_id, rsp_data);
    modport slave  (input  req_valid, req_op, req_a, req_b, req_lock, rsp_ready,
                    output req_ready, rsp_valid, rsp_id, rsp_data);
`else
    modport master (output req_valid, req_op, req_a, req_b, rsp_ready,
                    input  req_ready, rsp_valid, rsp_id, rsp_data);
    modport slave  (input  req_valid, req_op, req_a, req_b, rsp_ready,
                    output req_ready, rsp_valid, rsp_id, rsp_data);
`endif

endinterface

// File: rtl/alu_rr_arbiter_alu.sv
// 32-bit ALU shared by all requesters; purely combinational, no flags.
module alu_rr_alu
  import alu_arb_pkg::*;
(
    input  logic [3:0]    op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] y_o
);

    logic [4:0]      sh;
    logic [2*DW-1:0] ror_w;

    assign sh    = b_i[4:0];
    assign ror_w = {a_i, a_i} >> sh;

    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_NEG:  y_o = '0 - b_i;
            ALU_NOT:  y_o = ~b_i;
            ALU_AND:  y_o = a_i & b_i;
            ALU_OR:   y_o = a_i | b_i;
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_SRL:  y_o = a_i >> sh;
            ALU_SRA:  y_o = $signed(a_i) >>> sh;
            ALU_SLL:  y_o = a_i << sh;
            ALU_ROR:  y_o = ror_w[DW-1:0];
            ALU_PASS: y_o = b_i;
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_arbiter_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr_i, wrapping.
module alu_rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    always_comb begin
        int j;
        // NOTE: every output gets a default before any branch, so no path infers a latch.
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        // Scan from the farthest offset down so the nearest valid one wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (valid_i[j]) begin
                idx_o = IW'(j);
                any_o = 1'b1;
            end
        end
        if (any_o) gnt_o = NREQ'(1) << idx_o;
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_LOCK_EN to add REQ_LOCK, which pins grants to one requester.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    alu_rr_arbiter_if.slave    bus
);

    localparam int IW = idx_w(NREQ);

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] valid_eff, gnt;
    logic [IW-1:0]   gidx;
    logic            any, grant_en, hs;

    logic [3:0]      sel_op, op_q;
    logic [DW-1:0]   sel_a, sel_b, a_q, b_q, alu_y;
    logic [IW-1:0]   id_q, rsp_id_q;
    logic [DW-1:0]   rsp_data_q;
    logic            rsp_valid_q;

`ifdef ALU_ARB_LOCK_EN
    logic            lock_q, sel_lock;
    logic [IW-1:0]   lock_id_q;

    assign valid_eff = lock_q ? (bus.req_valid & (NREQ'(1) << lock_id_q)) : bus.req_valid;
    assign sel_lock  = bus.req_lock[gidx];
`else
    assign valid_eff = bus.req_valid;
`endif

    alu_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .valid_i (valid_eff),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .idx_o   (gidx),
        .any_o   (any)
    );

    // Grants are offered in IDLE or while the pending result is being consumed; never in reset.
    assign grant_en = rst_ni & ((state_q == IDLE) | ((state_q == RESP) & bus.rsp_ready));
    assign hs       = grant_en & any;

    assign sel_op = bus.req_op[4*gidx +: 4];
    assign sel_a  = bus.req_a[DW*gidx +: DW];
    assign sel_b  = bus.req_b[DW*gidx +: DW];

    always_comb begin
        ptr_d = ptr_q;
        if (hs) ptr_d = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
`ifdef ALU_ARB_LOCK_EN
        if (hs && sel_lock) ptr_d = ptr_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (hs) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = hs ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = grant_en ? gnt : '0;
    end

    // NOTE: all state uses non-blocking assignments so each flop sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            id_q <= '0;
        end else if (hs) begin
            op_q <= sel_op;
            a_q  <= sel_a;
            b_q  <= sel_b;
            id_q <= gidx;
        end
    end

    alu_rr_alu u_alu (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .y_o  (alu_y)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else if (state_q == EXEC) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= alu_y;
            rsp_id_q    <= id_q;
        end else if (state_q == RESP && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

`ifdef ALU_ARB_LOCK_EN
    // A grant taken with its lock bit set pins the next grant to the same requester.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else if (hs) begin
            lock_q    <= sel_lock;
            lock_id_q <= gidx;
        end
    end
`endif

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed self-checking bench for alu_rr_arbiter with two requesters; the lock
// scenario runs only when ALU_ARB_LOCK_EN is defined.
module tb_alu_rr_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_rr_arbiter_if #(.NREQ(2)) bus ();

    alu_rr_arbiter #(.NREQ(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;

    vec_t vecs [14];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        bus.req_valid[i]        = v;
        bus.req_op[4*i +: 4]    = op;
        bus.req_a[32*i +: 32]   = a;
        bus.req_b[32*i +: 32]   = b;
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
`ifdef ALU_ARB_LOCK_EN
        bus.req_lock  = '0;
`endif
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One operation from IDLE with a single valid requester; ok=0 on timeout.
    task automatic do_op(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] data,
                         output int id, output bit ok);
        ok   = 1'b0;
        data = '0;
        id   = -1;
        bus.rsp_ready = 1'b1;
        set_req(i, 1'b1, op, a, b);
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.req_ready[i]) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) begin bus.req_valid[i] = 1'b0; return; end
        tick();
        bus.req_valid[i] = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.rsp_valid) begin
                ok   = 1'b1;
                data = bus.rsp_data;
                id   = int'(bus.rsp_id);
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b1;
        tick();
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id: got %b want 0", bus.rsp_id); end
        n_checks++; if (bus.rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
        n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
        apply_reset();
    endtask

    task automatic test_add();
        set_req(0, 1'b1, 4'd1, 32'd5, 32'd7);
        #1;
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL add_grant: got %b want 01", bus.req_ready); end
        tick();
        bus.req_valid[0] = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL add_exec: rsp_valid %b req_ready %b want 0/00", bus.rsp_valid, bus.req_ready); end
        tick();
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd12 || bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL add_rsp: valid %b data %h id %b want 1/0000000c/0", bus.rsp_valid, bus.rsp_data, bus.rsp_id); end
        tick();
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_idle: rsp_valid %b want 0", bus.rsp_valid); end
        tick();
    endtask

    task automatic test_ops();
        logic [31:0] data;
        int          id;
        bit          ok;
        apply_reset();
        set_req(0, 1'b1, 4'd2, 32'd10, 32'd3);
        set_req(1, 1'b1, 4'd11, 32'h1, 32'd1);
        #1;
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL ops_first_grant: got %b want 01", bus.req_ready); end
        tick();
        bus.req_valid[0] = 1'b0;
        tick();
        #1;
        n_checks++; if (bus.rsp_data !== 32'd7 || bus.rsp_id !== 1'b0 || bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL ops_sub: data %h id %b valid %b want 00000007/0/1", bus.rsp_data, bus.rsp_id, bus.rsp_valid); end
        n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL ops_second_grant: got %b want 10", bus.req_ready); end
        tick();
        bus.req_valid[1] = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ops_consumed: rsp_valid %b want 0", bus.rsp_valid); end
        tick();
        #1;
        n_checks++; if (bus.rsp_data !== 32'h80000000 || bus.rsp_id !== 1'b1) begin n_fail++; $display("FAIL ops_ror: data %h id %b want 80000000/1", bus.rsp_data, bus.rsp_id); end
        tick();

        vecs = '{
            '{4'd9,  32'h80000000, 32'd4,        32'hF8000000},
            '{4'd0,  32'hDEADBEEF, 32'h00001234, 32'h00000000},
            '{4'd1,  32'hFFFFFFFF, 32'd2,        32'h00000001},
            '{4'd3,  32'h00000000, 32'd5,        32'hFFFFFFFB},
            '{4'd4,  32'h00000000, 32'h0F0F0F0F, 32'hF0F0F0F0},
            '{4'd8,  32'h80000000, 32'd4,        32'h08000000},
            '{4'd10, 32'h00000001, 32'd31,       32'h80000000},
            '{4'd11, 32'h12345678, 32'd8,        32'h78123456},
            '{4'd12, 32'h00000001, 32'hCAFEBABE, 32'hCAFEBABE},
            '{4'd15, 32'h00000001, 32'h00000001, 32'h00000000},
            '{4'd6,  32'h000000F0, 32'h0000000F, 32'h000000FF},
            '{4'd7,  32'h000000FF, 32'h0000000F, 32'h000000F0},
            '{4'd10, 32'h00000001, 32'h00000021, 32'h00000002},
            '{4'd11, 32'h000000A5, 32'h00000000, 32'h000000A5}
        };
        for (int k = 0; k < 14; k++) begin
            do_op(k % 2, vecs[k].op, vecs[k].a, vecs[k].b, data, id, ok);
            n_checks++; if (!ok || data !== vecs[k].y || id != k % 2) begin n_fail++; $display("FAIL ops_vec%0d: ok %0d data %h id %0d want %h id %0d", k, ok, data, id, vecs[k].y, k % 2); end
        end
    endtask

    task automatic test_back_to_back();
        int          gnt_id [8];
        int          gnt_cyc[8];
        int          rsp_id [8];
        logic [31:0] rsp_dat[8];
        int          ng = 0;
        int          nr = 0;
        apply_reset();
        set_req(0, 1'b1, 4'd1, 32'd1, 32'd2);
        set_req(1, 1'b1, 4'd7, 32'hF0, 32'hFF);
        for (int c = 0; c < 16; c++) begin
            #1;
            if (bus.req_ready != 2'b00 && ng < 8) begin
                gnt_id[ng]  = (bus.req_ready == 2'b01) ? 0 : (bus.req_ready == 2'b10) ? 1 : -1;
                gnt_cyc[ng] = c;
                ng++;
            end
            if (bus.rsp_valid && nr < 8) begin
                rsp_id[nr]  = int'(bus.rsp_id);
                rsp_dat[nr] = bus.rsp_data;
                nr++;
            end
            tick();
            if (ng == 6) bus.req_valid = 2'b00;
        end
        n_checks++; if (ng != 6) begin n_fail++; $display("FAIL b2b_grant_count: got %0d want 6", ng); end
        n_checks++; if (nr != 6) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d want 6", nr); end
        for (int k = 0; k < 6 && k < ng; k++) begin
            n_checks++; if (gnt_id[k] != k % 2 || gnt_cyc[k] != 2 * k) begin n_fail++; $display("FAIL b2b_grant%0d: id %0d cycle %0d want id %0d cycle %0d", k, gnt_id[k], gnt_cyc[k], k % 2, 2 * k); end
        end
        for (int k = 0; k < 6 && k < nr; k++) begin
            n_checks++; if (rsp_id[k] != k % 2 || rsp_dat[k] !== ((k % 2 == 0) ? 32'd3 : 32'h0F)) begin n_fail++; $display("FAIL b2b_rsp%0d: id %0d data %h", k, rsp_id[k], rsp_dat[k]); end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b1, 4'd5, 32'hFF00FF00, 32'h0FF00FF0);
        set_req(1, 1'b1, 4'd6, 32'h1, 32'h2);
        #1;
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_grant0: got %b want 01", bus.req_ready); end
        tick();
        bus.req_valid[0] = 1'b0;
        #1;
        n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_exec_ready: got %b want 00", bus.req_ready); end
        tick();
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0F000F00 || bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL bp_rsp0: valid %b data %h id %b want 1/0f000f00/0", bus.rsp_valid, bus.rsp_data, bus.rsp_id); end
        for (int c = 0; c < 5; c++) begin
            tick();
            #1;
            n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0F000F00 || bus.rsp_id !== 1'b0 || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_hold%0d: valid %b data %h id %b ready %b", c, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready); end
        end
        bus.rsp_ready = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_grant1: got %b want 10", bus.req_ready); end
        tick();
        bus.req_valid[1] = 1'b0;
        tick();
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd3 || bus.rsp_id !== 1'b1) begin n_fail++; $display("FAIL bp_rsp1: valid %b data %h id %b want 1/00000003/1", bus.rsp_valid, bus.rsp_data, bus.rsp_id); end
        tick();
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle: rsp_valid %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_req(0, 1'b1, 4'd1, 32'd1, 32'd1);
        set_req(1, 1'b1, 4'd1, 32'd2, 32'd2);
        #1;
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_pre_grant: got %b want 01", bus.req_ready); end
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_in_exec: rsp_valid %b req_ready %b want 0/00", bus.rsp_valid, bus.req_ready); end
        bus.req_valid = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stale%0d: rsp_valid %b want 0", c, bus.rsp_valid); end
            tick();
        end
        set_req(0, 1'b1, 4'd1, 32'd20, 32'd22);
        set_req(1, 1'b1, 4'd1, 32'd3, 32'd4);
        #1;
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_post_grant: got %b want 01", bus.req_ready); end
        tick();
        bus.req_valid[0] = 1'b0;
        tick();
        #1;
        n_checks++; if (bus.rsp_data !== 32'd42 || bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL rst_post_rsp: data %h id %b want 0000002a/0", bus.rsp_data, bus.rsp_id); end
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
    endtask

`ifdef ALU_ARB_LOCK_EN
    task automatic test_lock();
        apply_reset();
        set_req(1, 1'b1, 4'd1, 32'd1, 32'd1);
        bus.req_lock = 2'b10;
        #1;
        n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL lock_grant1: got %b want 10", bus.req_ready); end
        tick();
        set_req(0, 1'b1, 4'd1, 32'd9, 32'd9);
        set_req(1, 1'b1, 4'd2, 32'd9, 32'd4);
        bus.req_lock = 2'b00;
        tick();
        #1;
        n_checks++; if (bus.rsp_data !== 32'd2 || bus.rsp_id !== 1'b1) begin n_fail++; $display("FAIL lock_rsp1: data %h id %b want 00000002/1", bus.rsp_data, bus.rsp_id); end
        n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL lock_grant2: got %b want 10", bus.req_ready); end
        tick();
        bus.req_valid[1] = 1'b0;
        tick();
        #1;
        n_checks++; if (bus.rsp_data !== 32'd5 || bus.rsp_id !== 1'b1) begin n_fail++; $display("FAIL lock_rsp2: data %h id %b want 00000005/1", bus.rsp_data, bus.rsp_id); end
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL lock_release_grant: got %b want 01", bus.req_ready); end
        tick();
        bus.req_valid[0] = 1'b0;
        tick();
        #1;
        n_checks++; if (bus.rsp_data !== 32'd18 || bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL lock_rsp3: data %h id %b want 00000012/0", bus.rsp_data, bus.rsp_id); end
        tick();
    endtask
`endif

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
`ifdef ALU_ARB_LOCK_EN
        bus.req_lock  = '0;
`endif
        test_reset();
        test_add();
        test_ops();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef ALU_ARB_LOCK_EN
        test_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
